// File: rtl/trap_controller_pkg.sv
// Shared types and cause codes for the writeback trap sequencer.
package trap_controller_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRAP     = 2'd1,
      RET      = 2'd2,
      REDIRECT = 2'd3
   } trapState_e;

   localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
   localparam logic [3:0] IRQ_CAUSE_DEFAULT      = 4'd11;

endpackage

// File: rtl/trap_controller_irq_synchronizer.sv
// Multi-flop synchronizer that brings the level-sensitive external interrupt into the clock domain.
module irq_synchronizer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_irq,
   output logic sync_irq
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stages <= '0;
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], async_irq};
      end
   end

   assign sync_irq = stages[SYNC_STAGES-1];

endmodule

// File: rtl/trap_controller.sv
// Writeback-stage trap sequencer: exceptions, interrupts and MRET become CSR strobes,
// followed by a pipeline flush and a fetch redirect handshake.
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int         SYNC_STAGES    = 2,
   parameter int         HOLDOFF_CYCLES = 4,
   parameter logic [3:0] IRQ_CAUSE      = IRQ_CAUSE_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        interrupt,
   input  logic        mstatusMIE,
   input  logic [31:0] trapVector,
   input  logic [31:0] mepc,
   input  logic        wbValid,
   input  logic [31:0] wbPC,
   input  logic        wbExceptionPending,
   input  logic [3:0]  wbExceptionCause,
   input  logic [31:0] wbExceptionValue,
   input  logic        wbMret,
   input  logic        redirectReady,
   output logic        controlReset,
   output logic [3:0]  mcause,
   output logic [31:0] mtval,
   output logic [31:0] trapPC,
   output logic        trapIsInterrupt,
   output logic        mretSignal,
   output logic        wbSuppress,
   output logic        flush,
   output logic        redirectValid,
   output logic [31:0] redirectPC
);

   localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

   trapState_e  state;
   logic [HOLD_W-1:0] holdoff;
   logic        irq_sync;
   logic        idle_valid;
   logic        irq_take;
   logic        exc_take;
   logic        int_take;
   logic        ret_take;

   irq_synchronizer #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_irq_sync (
      .clock     (clock),
      .reset     (reset),
      .async_irq (interrupt),
      .sync_irq  (irq_sync)
   );

   assign idle_valid = (state == IDLE) & wbValid;
   assign irq_take   = irq_sync & mstatusMIE & idle_valid & (holdoff == '0);
   assign exc_take   = idle_valid & wbExceptionPending;
   assign int_take   = irq_take & ~exc_take;
   assign ret_take   = idle_valid & wbMret & ~exc_take & ~int_take;
   // Gated by reset so every output reads 0 while reset is held, even this combinational one.
   assign wbSuppress = reset & (exc_take | int_take);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         holdoff         <= '0;
         controlReset    <= 1'b0;
         mcause          <= 4'd0;
         mtval           <= 32'd0;
         trapPC          <= 32'd0;
         trapIsInterrupt <= 1'b0;
         mretSignal      <= 1'b0;
         flush           <= 1'b0;
         redirectValid   <= 1'b0;
         redirectPC      <= 32'd0;
      end else begin
         controlReset <= 1'b0;
         mretSignal   <= 1'b0;
         if (holdoff != '0) begin
            holdoff <= holdoff - HOLD_W'(1);
         end

         case (state)
            IDLE: begin
               if (exc_take) begin
                  mcause          <= wbExceptionCause;
                  mtval           <= wbExceptionValue;
                  trapPC          <= wbPC;
                  trapIsInterrupt <= 1'b0;
                  controlReset    <= 1'b1;
                  flush           <= 1'b1;
                  state           <= TRAP;
               end else if (int_take) begin
                  mcause          <= IRQ_CAUSE;
                  mtval           <= 32'd0;
                  trapPC          <= wbPC;
                  trapIsInterrupt <= 1'b1;
                  controlReset    <= 1'b1;
                  flush           <= 1'b1;
                  state           <= TRAP;
               end else if (ret_take) begin
                  mretSignal <= 1'b1;
                  flush      <= 1'b1;
                  state      <= RET;
               end
            end
            // Target is sampled here, one edge after the CSR strobe, so the CSR write is visible.
            TRAP: begin
               redirectValid <= 1'b1;
               redirectPC    <= trapVector;
               state         <= REDIRECT;
            end
            RET: begin
               redirectValid <= 1'b1;
               redirectPC    <= mepc;
               state         <= REDIRECT;
            end
            REDIRECT: begin
               if (redirectValid && redirectReady) begin
                  redirectValid <= 1'b0;
                  flush         <= 1'b0;
                  holdoff       <= HOLD_W'(HOLDOFF_CYCLES);
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller: exception, interrupt, MRET, priority, stall, reset abort.
module tb_trap_controller;

   logic        clock;
   logic        reset;
   logic        interrupt;
   logic        mstatusMIE;
   logic [31:0] trapVector;
   logic [31:0] mepc;
   logic        wbValid;
   logic [31:0] wbPC;
   logic        wbExceptionPending;
   logic [3:0]  wbExceptionCause;
   logic [31:0] wbExceptionValue;
   logic        wbMret;
   logic        redirectReady;
   logic        controlReset;
   logic [3:0]  mcause;
   logic [31:0] mtval;
   logic [31:0] trapPC;
   logic        trapIsInterrupt;
   logic        mretSignal;
   logic        wbSuppress;
   logic        flush;
   logic        redirectValid;
   logic [31:0] redirectPC;

   int total = 0;
   int bad   = 0;

   trap_controller #(
      .SYNC_STAGES(2),
      .HOLDOFF_CYCLES(4),
      .IRQ_CAUSE(4'd11)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .interrupt          (interrupt),
      .mstatusMIE         (mstatusMIE),
      .trapVector         (trapVector),
      .mepc               (mepc),
      .wbValid            (wbValid),
      .wbPC               (wbPC),
      .wbExceptionPending (wbExceptionPending),
      .wbExceptionCause   (wbExceptionCause),
      .wbExceptionValue   (wbExceptionValue),
      .wbMret             (wbMret),
      .redirectReady      (redirectReady),
      .controlReset       (controlReset),
      .mcause             (mcause),
      .mtval              (mtval),
      .trapPC             (trapPC),
      .trapIsInterrupt    (trapIsInterrupt),
      .mretSignal         (mretSignal),
      .wbSuppress         (wbSuppress),
      .flush              (flush),
      .redirectValid      (redirectValid),
      .redirectPC         (redirectPC)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle 1 time unit past the edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      wbValid = 1'b0;
      wbExceptionPending = 1'b0;
      wbMret = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      interrupt = 1'b0; mstatusMIE = 1'b0; trapVector = 32'h100; mepc = 32'h0;
      wbValid = 1'b0; wbPC = 32'h0; wbExceptionPending = 1'b0; wbExceptionCause = 4'd0;
      wbExceptionValue = 32'h0; wbMret = 1'b0; redirectReady = 1'b1;
      #3;
      total++;
      if ({controlReset, mretSignal, wbSuppress, flush, redirectValid, trapIsInterrupt} !== 6'b0) begin
         bad++; $display("FAIL reset_strobes: got %b want 000000",
            {controlReset, mretSignal, wbSuppress, flush, redirectValid, trapIsInterrupt});
      end
      total++;
      if ({mcause, mtval, trapPC, redirectPC} !== 100'd0) begin
         bad++; $display("FAIL reset_data: mcause=%h mtval=%h trapPC=%h redirectPC=%h want all 0",
            mcause, mtval, trapPC, redirectPC);
      end
      cyc(); cyc();
      reset = 1'b1;
      cyc();
      $display("test_reset done");
   endtask

   task automatic test_exception();
      trapVector = 32'h0000_0100;
      wbValid = 1'b1; wbExceptionPending = 1'b1; wbExceptionCause = 4'd2;
      wbExceptionValue = 32'h0000_FFFF; wbPC = 32'h0000_0040;
      #1;
      total++;
      if (wbSuppress !== 1'b1) begin bad++; $display("FAIL exc_suppress: got %b want 1", wbSuppress); end
      cyc();
      wbValid = 1'b0; wbExceptionPending = 1'b0;
      total++;
      if (controlReset !== 1'b1 || flush !== 1'b1 || redirectValid !== 1'b0) begin
         bad++; $display("FAIL exc_trap_strobe: cr=%b flush=%b rv=%b want 1 1 0", controlReset, flush, redirectValid);
      end
      total++;
      if (mcause !== 4'd2 || mtval !== 32'h0000_FFFF || trapPC !== 32'h40 || trapIsInterrupt !== 1'b0) begin
         bad++; $display("FAIL exc_fields: mcause=%h mtval=%h trapPC=%h irq=%b want 2 0000ffff 00000040 0",
            mcause, mtval, trapPC, trapIsInterrupt);
      end
      cyc();
      total++;
      if (controlReset !== 1'b0 || redirectValid !== 1'b1 || redirectPC !== 32'h100 || flush !== 1'b1) begin
         bad++; $display("FAIL exc_redirect: cr=%b rv=%b pc=%h flush=%b want 0 1 00000100 1",
            controlReset, redirectValid, redirectPC, flush);
      end
      cyc();
      total++;
      if (redirectValid !== 1'b0 || flush !== 1'b0) begin
         bad++; $display("FAIL exc_release: rv=%b flush=%b want 0 0", redirectValid, flush);
      end
      idle(6);
      $display("test_exception done");
   endtask

   task automatic test_interrupt();
      interrupt = 1'b1; mstatusMIE = 1'b1; wbValid = 1'b1; wbPC = 32'h0000_0080;
      cyc();
      total++;
      if (controlReset !== 1'b0) begin bad++; $display("FAIL irq_early1: cr=%b want 0", controlReset); end
      cyc();
      total++;
      if (controlReset !== 1'b0 || wbSuppress !== 1'b1) begin
         bad++; $display("FAIL irq_early2: cr=%b supp=%b want 0 1", controlReset, wbSuppress);
      end
      cyc();
      interrupt = 1'b0; wbValid = 1'b0;
      total++;
      if (controlReset !== 1'b1) begin bad++; $display("FAIL irq_latency: cr=%b want 1", controlReset); end
      total++;
      if (mcause !== 4'd11 || trapIsInterrupt !== 1'b1 || mtval !== 32'h0 || trapPC !== 32'h80) begin
         bad++; $display("FAIL irq_fields: mcause=%h irq=%b mtval=%h trapPC=%h want b 1 0 80",
            mcause, trapIsInterrupt, mtval, trapPC);
      end
      cyc();
      total++;
      if (redirectValid !== 1'b1 || redirectPC !== 32'h100) begin
         bad++; $display("FAIL irq_redirect: rv=%b pc=%h want 1 00000100", redirectValid, redirectPC);
      end
      cyc();
      idle(6);
      $display("test_interrupt done");
   endtask

   task automatic test_mret();
      mepc = 32'h0000_0044; wbValid = 1'b1; wbMret = 1'b1; wbPC = 32'h0000_0090;
      #1;
      total++;
      if (wbSuppress !== 1'b0) begin bad++; $display("FAIL mret_suppress: got %b want 0", wbSuppress); end
      cyc();
      wbValid = 1'b0; wbMret = 1'b0;
      total++;
      if (mretSignal !== 1'b1 || controlReset !== 1'b0 || flush !== 1'b1) begin
         bad++; $display("FAIL mret_strobe: mret=%b cr=%b flush=%b want 1 0 1", mretSignal, controlReset, flush);
      end
      cyc();
      total++;
      if (mretSignal !== 1'b0 || redirectValid !== 1'b1 || redirectPC !== 32'h44) begin
         bad++; $display("FAIL mret_redirect: mret=%b rv=%b pc=%h want 0 1 00000044",
            mretSignal, redirectValid, redirectPC);
      end
      cyc();
      idle(6);
      $display("test_mret done");
   endtask

   task automatic test_priority();
      interrupt = 1'b1; mstatusMIE = 1'b1;
      idle(3);
      wbValid = 1'b1; wbExceptionPending = 1'b1; wbExceptionCause = 4'd3;
      wbExceptionValue = 32'h0000_1234; wbPC = 32'h0000_0200;
      #1;
      total++;
      if (wbSuppress !== 1'b1) begin bad++; $display("FAIL prio_suppress: got %b want 1", wbSuppress); end
      cyc();
      wbValid = 1'b0; wbExceptionPending = 1'b0;
      total++;
      if (controlReset !== 1'b1 || mcause !== 4'd3 || trapIsInterrupt !== 1'b0 || mtval !== 32'h1234) begin
         bad++; $display("FAIL prio_exc_wins: cr=%b mcause=%h irq=%b mtval=%h want 1 3 0 00001234",
            controlReset, mcause, trapIsInterrupt, mtval);
      end
      cyc();
      cyc();
      wbValid = 1'b1; wbPC = 32'h0000_0204;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         total++;
         if (controlReset !== 1'b0) begin
            bad++; $display("FAIL prio_holdoff_%0d: cr=%b want 0", k, controlReset);
         end
      end
      cyc();
      interrupt = 1'b0; wbValid = 1'b0;
      total++;
      if (controlReset !== 1'b1 || mcause !== 4'd11 || trapIsInterrupt !== 1'b1 || trapPC !== 32'h204) begin
         bad++; $display("FAIL prio_irq_after: cr=%b mcause=%h irq=%b trapPC=%h want 1 b 1 00000204",
            controlReset, mcause, trapIsInterrupt, trapPC);
      end
      cyc(); cyc();
      idle(6);
      $display("test_priority done");
   endtask

   task automatic test_stall();
      redirectReady = 1'b0; trapVector = 32'h0000_0101;
      wbValid = 1'b1; wbExceptionPending = 1'b1; wbExceptionCause = 4'd0;
      wbExceptionValue = 32'h0000_0301; wbPC = 32'h0000_0300;
      cyc();
      wbValid = 1'b0; wbExceptionPending = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         total++;
         if (redirectValid !== 1'b1 || redirectPC !== 32'h101 || flush !== 1'b1 || controlReset !== 1'b0) begin
            bad++; $display("FAIL stall_hold_%0d: rv=%b pc=%h flush=%b cr=%b want 1 00000101 1 0",
               i, redirectValid, redirectPC, flush, controlReset);
         end
      end
      redirectReady = 1'b1;
      cyc();
      total++;
      if (redirectValid !== 1'b0 || flush !== 1'b0) begin
         bad++; $display("FAIL stall_release: rv=%b flush=%b want 0 0", redirectValid, flush);
      end
      idle(6);
      $display("test_stall done");
   endtask

   task automatic test_reset_mid();
      redirectReady = 1'b0;
      wbValid = 1'b1; wbExceptionPending = 1'b1; wbExceptionCause = 4'd2;
      wbExceptionValue = 32'h0000_0BAD; wbPC = 32'h0000_0400;
      cyc();
      wbValid = 1'b0; wbExceptionPending = 1'b0;
      cyc();
      total++;
      if (redirectValid !== 1'b1) begin bad++; $display("FAIL rmid_pre: rv=%b want 1", redirectValid); end
      #2;
      wbValid = 1'b1; wbExceptionPending = 1'b1;
      reset = 1'b0;
      #1;
      total++;
      if ({controlReset, mretSignal, wbSuppress, flush, redirectValid, trapIsInterrupt} !== 6'b0) begin
         bad++; $display("FAIL rmid_strobes: got %b want 000000",
            {controlReset, mretSignal, wbSuppress, flush, redirectValid, trapIsInterrupt});
      end
      total++;
      if ({mcause, mtval, trapPC, redirectPC} !== 100'd0) begin
         bad++; $display("FAIL rmid_data: mcause=%h mtval=%h trapPC=%h redirectPC=%h want all 0",
            mcause, mtval, trapPC, redirectPC);
      end
      wbValid = 1'b0; wbExceptionPending = 1'b0;
      cyc();
      reset = 1'b1; redirectReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         total++;
         if (controlReset !== 1'b0 || mretSignal !== 1'b0 || redirectValid !== 1'b0) begin
            bad++; $display("FAIL rmid_after_%0d: cr=%b mret=%b rv=%b want 0 0 0",
               i, controlReset, mretSignal, redirectValid);
         end
      end
      $display("test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_exception();
      test_interrupt();
      test_mret();
      test_priority();
      test_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
